// File: rtl/mir_decoder.sv
// mir_decoder: microprogram sequencer. It decodes a 31-bit microinstruction
// into control strobes and the next control-store address. Every output is
// registered, so addr and the strobes reflect the instruction executed on the
// previous clock edge.
// Optional feature: define MIR_TIMEOUT_EN to add a memory-wait watchdog.
// When the watchdog expires it sets err and parks the sequencer in HALT.
module mir_decoder #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [7:0]  HALT_ADDR      = 8'd56
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [30:0] mir,
    input  logic        z_flag,
    input  logic [7:0]  opcode,
    input  logic        mem_ready,
    output logic [7:0]  addr,
    output logic [11:0] bus_sel,
    output logic [8:0]  reg_we,
    output logic [3:0]  alu_op,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        pc_inc,
    output logic        busy,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [11:0] bus_sel_q, bus_sel_d;
    logic [8:0]  reg_we_q, reg_we_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        pc_inc_q, pc_inc_d;
    logic        busy_q, busy_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    // A memory instruction's writeback is held here until mem_ready arrives,
    // because the mir input is free to change while the access is in flight.
    logic [7:0]  pend_addr_q, pend_addr_d;
    logic [8:0]  pend_we_q, pend_we_d;
    logic [3:0]  pend_alu_q, pend_alu_d;
    logic        pend_pci_q, pend_pci_d;
    logic        pend_halt_q, pend_halt_d;

`ifdef MIR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [7:0]  f_next;
    logic [1:0]  f_mode;
    logic [3:0]  f_bsrc;
    logic [8:0]  f_we;
    logic [2:0]  f_mem;
    logic        f_pci;
    logic [3:0]  f_alu;

    assign f_next = mir[30:23];
    assign f_mode = mir[22:21];
    assign f_bsrc = mir[20:17];
    assign f_we   = mir[16:8];
    assign f_mem  = mir[7:5];
    assign f_pci  = mir[4];
    assign f_alu  = mir[3:0];

    logic [7:0]  dec_addr;
    logic        dec_halt;
    logic [11:0] dec_bus_sel;
    logic        dec_bsrc_bad;
    logic        dec_rd;
    logic        dec_wr;
    logic        dec_mem_bad;

    // Decode the current microinstruction fields independently of state.
    always_comb begin
        dec_addr     = f_next;
        dec_halt     = 1'b0;
        dec_bus_sel  = 12'd0;
        dec_bsrc_bad = 1'b0;
        dec_rd       = 1'b0;
        dec_wr       = 1'b0;
        dec_mem_bad  = 1'b0;
        case (f_mode)
            2'b00: dec_addr = f_next;
            2'b01: dec_addr = opcode;
            2'b10: begin
                dec_addr = HALT_ADDR;
                dec_halt = 1'b1;
            end
            default: dec_addr = z_flag ? f_next : f_next + 8'd1;
        endcase
        if (f_bsrc >= 4'd13) begin
            dec_bsrc_bad = 1'b1;
        end else if (f_bsrc != 4'd0) begin
            dec_bus_sel = 12'd1 << (f_bsrc - 4'd1);
        end
        case (f_mem)
            3'b100:  dec_rd      = 1'b1;
            3'b010:  dec_wr      = 1'b1;
            3'b000:  dec_rd      = 1'b0;
            default: dec_mem_bad = 1'b1;
        endcase
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bus_sel_d   = 12'd0;
        reg_we_d    = 9'd0;
        alu_op_d    = 4'd0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        pc_inc_d    = 1'b0;
        err_d       = err_q;
        pend_addr_d = pend_addr_q;
        pend_we_d   = pend_we_q;
        pend_alu_d  = pend_alu_q;
        pend_pci_d  = pend_pci_q;
        pend_halt_d = pend_halt_q;
`ifdef MIR_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                addr_d = 8'd0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dec_bsrc_bad || dec_mem_bad) begin
                    err_d = 1'b1;
                end
                if (dec_rd || dec_wr) begin
                    mem_rd_d    = dec_rd;
                    mem_wr_d    = dec_wr;
                    pend_addr_d = dec_addr;
                    pend_we_d   = f_we;
                    pend_alu_d  = f_alu;
                    pend_pci_d  = f_pci;
                    pend_halt_d = dec_halt;
                    state_d     = MEM_WAIT;
`ifdef MIR_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end else begin
                    addr_d    = dec_addr;
                    bus_sel_d = dec_bus_sel;
                    reg_we_d  = f_we;
                    alu_op_d  = f_alu;
                    pc_inc_d  = f_pci;
                    if (dec_halt) begin
                        state_d = HALT;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    addr_d   = pend_addr_q;
                    reg_we_d = pend_we_q;
                    alu_op_d = pend_alu_q;
                    pc_inc_d = pend_pci_q;
                    if (pend_halt_q) begin
                        state_d = HALT;
                    end else if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    mem_rd_d = mem_rd_q;
                    mem_wr_d = mem_wr_q;
`ifdef MIR_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_rd_d = 1'b0;
                        mem_wr_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = HALT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: begin
                addr_d = HALT_ADDR;
            end
        endcase
        busy_d   = (state_d == RUN) || (state_d == MEM_WAIT);
        halted_d = (state_d == HALT);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= 8'd0;
            bus_sel_q   <= 12'd0;
            reg_we_q    <= 9'd0;
            alu_op_q    <= 4'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            pc_inc_q    <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            pend_addr_q <= 8'd0;
            pend_we_q   <= 9'd0;
            pend_alu_q  <= 4'd0;
            pend_pci_q  <= 1'b0;
            pend_halt_q <= 1'b0;
`ifdef MIR_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bus_sel_q   <= bus_sel_d;
            reg_we_q    <= reg_we_d;
            alu_op_q    <= alu_op_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            pc_inc_q    <= pc_inc_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            pend_addr_q <= pend_addr_d;
            pend_we_q   <= pend_we_d;
            pend_alu_q  <= pend_alu_d;
            pend_pci_q  <= pend_pci_d;
            pend_halt_q <= pend_halt_d;
`ifdef MIR_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign addr    = addr_q;
    assign bus_sel = bus_sel_q;
    assign reg_we  = reg_we_q;
    assign alu_op  = alu_op_q;
    assign mem_rd  = mem_rd_q;
    assign mem_wr  = mem_wr_q;
    assign pc_inc  = pc_inc_q;
    assign busy    = busy_q;
    assign halted  = halted_q;
    assign err     = err_q;

endmodule

// File: doc/mir_decoder.md
MIR_DECODER -- requirements
Module: mir_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: memory-wait cycle limit, used only with MIR_TIMEOUT_EN.
REQ-002 Parameter HALT_ADDR, default 8'd56: micro-address emitted while halted.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; start execution when high.
REQ-006 mir  input  31  microinstruction word: [30:23] NEXT, [22:21] MODE, [20:17] BSRC, [16:8] WE, [7:5] MEM, [4] PCI, [3:0] ALU.
REQ-007 z_flag  input  1  ALU zero flag.
REQ-008 opcode  input  8  instruction opcode used for dispatch.
REQ-009 mem_ready  input  1  memory completion strobe.
REQ-010 addr  output  8  next micro-address to the control store.
REQ-011 bus_sel  output  12  one-hot bus-source select decoded from BSRC.
REQ-012 reg_we  output  9  register write enables.
REQ-013 alu_op  output  4  ALU operation.
REQ-014 mem_rd, mem_wr  output  1 each  memory strobes.
REQ-015 pc_inc  output  1  PC increment pulse.
REQ-016 busy, halted, err  output  1 each  status.

Function
REQ-017 States: IDLE, RUN, MEM_WAIT, HALT; all outputs registered.
REQ-018 IDLE: addr=0, all strobes 0; IDLE->RUN on the first clk with enable=1.
REQ-019 RUN: each cycle, decode the current mir and set addr for the next cycle (1-cycle latency).
REQ-020 MODE 00: addr=NEXT.
REQ-021 MODE 01: addr=opcode (dispatch).
REQ-022 MODE 10: addr=HALT_ADDR; go to HALT.
REQ-023 MODE 11: addr=NEXT when z_flag=1, else NEXT+1 (8-bit wrap, 8'hFF+1=8'h00).
REQ-024 BSRC=0: bus_sel=0. BSRC 1..12: bus_sel[BSRC-1]=1. BSRC 13..15: bus_sel=0 and err set (sticky).
REQ-025 reg_we=WE, alu_op=ALU, pc_inc=PCI, each for exactly one cycle per executed microinstruction.
REQ-026 MEM field: 100 -> read, 010 -> write, 000 -> none. Any other value: treated as none, err set.
REQ-027 A read or write enters MEM_WAIT. In MEM_WAIT: hold mem_rd/mem_wr high, hold addr, force reg_we=0, pc_inc=0, bus_sel=0; busy=1.
REQ-028 mem_ready in MEM_WAIT: deassert the strobe, emit the instruction's reg_we/alu_op/pc_inc for one cycle, apply its addr, return to RUN.
REQ-029 mem_ready outside MEM_WAIT is ignored.
REQ-030 busy=1 in RUN and MEM_WAIT; halted=1 only in HALT.
REQ-031 HALT: hold addr=HALT_ADDR, all strobes 0; leave only via reset.
REQ-032 enable low in RUN: finish the current instruction, then go to IDLE. In MEM_WAIT, wait for mem_ready first.
REQ-033 err clears only on reset.

Reset
REQ-034 reset_n low: immediately force IDLE, addr=0, bus_sel=0, reg_we=0, alu_op=0, mem_rd=0, mem_wr=0, pc_inc=0, busy=0, halted=0, err=0.
REQ-035 Reset asserted mid MEM_WAIT drops the strobes immediately; no partial writeback is issued.

Configuration
REQ-036 Macro MIR_TIMEOUT_EN defined: a counter runs in MEM_WAIT. After TIMEOUT_CYCLES cycles without mem_ready, set err, drop the strobes, and go to HALT.
REQ-037 Macro MIR_TIMEOUT_EN undefined: no counter is present, and MEM_WAIT waits indefinitely.

Verification
REQ-038 Reset, then enable=1, mir={8'd3,2'b00,4'd0,9'd0,3'b000,1'b0,4'd0} -> addr=3 one cycle after RUN is entered; busy=1.
REQ-039 MODE 11 with NEXT=8'd23: z_flag=1 -> addr=23; z_flag=0 -> addr=24; NEXT=8'hFF, z_flag=0 -> addr=0.
REQ-040 MEM=100, WE=9'h001, mem_ready asserted 3 cycles later -> mem_rd high for 3 cycles, reg_we=0 throughout, then reg_we=9'h001 for 1 cycle.
REQ-041 MODE 01 with opcode=8'h1D -> addr=29. MODE 10 -> addr=56, halted=1, stays halted with enable toggling.
REQ-042 BSRC=4'd5 -> bus_sel=12'h010. BSRC=4'd14 -> bus_sel=0, err=1 until reset.
REQ-043 With MIR_TIMEOUT_EN: MEM=010, no mem_ready -> after 16 cycles mem_wr=0, err=1, halted=1. Reset mid-wait -> all outputs 0 immediately.
